// File: rtl/move_master_arbiter.sv
// rtl/move_master_arbiter.sv - round-robin sharing of one Avalon-MM master among move-generation accelerators
module move_master_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ*32-1:0] req_address,
  input  logic [N_REQ-1:0]   req_read,
  input  logic [N_REQ-1:0]   req_write,
  input  logic [N_REQ*32-1:0] req_writedata,
  output logic [N_REQ-1:0]   req_waitrequest,
  output logic [31:0]        req_readdata,
  output logic [N_REQ-1:0]   req_readdatavalid,
  input  logic               master_waitrequest,
  output logic [31:0]        master_address,
  output logic               master_read,
  output logic               master_write,
  output logic [31:0]        master_writedata,
  input  logic [31:0]        master_readdata,
  input  logic               master_readdatavalid,
  output logic               busy,
  output logic [IDW-1:0]     grant_id
);

  typedef enum logic [1:0] {IDLE, GRANT, RD_WAIT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_last;
  logic [IDW-1:0]   r_grant_id;
  logic [IDW-1:0]   w_winner;
  logic [IDW-1:0]   w_cand;
  logic [IDW:0]     w_sum;
  logic             w_found;
  logic [N_REQ-1:0] w_requesting;
  logic [31:0]      w_addr  [N_REQ];
  logic [31:0]      w_wdata [N_REQ];
  logic             w_sel_read;
  logic             w_sel_write;

  assign w_requesting = req_read | req_write;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_addr[g]  = req_address[g*32 +: 32];
    assign w_wdata[g] = req_writedata[g*32 +: 32];
  end

  // Search starts just after the last winner and wraps; first requester found wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum = {1'b0, r_last} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(N_REQ)) w_sum = w_sum - (IDW+1)'(N_REQ);
      w_cand = w_sum[IDW-1:0];
      if (!w_found && w_requesting[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_sel_read  = req_read[r_grant_id];
  assign w_sel_write = req_write[r_grant_id] & ~req_read[r_grant_id];

  always_comb begin
    w_state_nxt       = r_state;
    master_read       = 1'b0;
    master_write      = 1'b0;
    master_address    = '0;
    master_writedata  = '0;
    req_waitrequest   = '1;
    req_readdatavalid = '0;
    case (r_state)
      IDLE: begin
        if (w_found) w_state_nxt = GRANT;
      end
      GRANT: begin
        master_read      = w_sel_read;
        master_write     = w_sel_write;
        master_address   = w_addr[r_grant_id];
        master_writedata = w_wdata[r_grant_id];
        if (!master_waitrequest) begin
          req_waitrequest[r_grant_id] = 1'b0;
          w_state_nxt = w_sel_read ? RD_WAIT : IDLE;
        end
      end
      RD_WAIT: begin
        // Responses outside RD_WAIT are strays and never reach a requester.
        if (master_readdatavalid) begin
          req_readdatavalid[r_grant_id] = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last     <= IDW'(N_REQ - 1);
      r_grant_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_found) begin
        r_last     <= w_winner;
        r_grant_id <= w_winner;
      end
    end
  end

  assign busy         = (r_state != IDLE);
  assign grant_id     = r_grant_id;
  assign req_readdata = master_readdata;

endmodule

// File: tb/tb_move_master_arbiter.sv
// tb/tb_move_master_arbiter.sv - randomized scoreboard bench for move_master_arbiter
module tb_move_master_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [N-1:0][31:0]  req_address_a;
  logic [N-1:0][31:0]  req_writedata_a;
  logic [N-1:0]        req_read, req_write, req_waitrequest, req_readdatavalid;
  logic [31:0]         req_readdata;
  logic                master_waitrequest, master_read, master_write, master_readdatavalid, busy;
  logic [31:0]         master_address, master_writedata, master_readdata;
  logic [IDW-1:0]      grant_id;

  move_master_arbiter #(.N_REQ(N), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_address(req_address_a), .req_read(req_read), .req_write(req_write),
    .req_writedata(req_writedata_a), .req_waitrequest(req_waitrequest),
    .req_readdata(req_readdata), .req_readdatavalid(req_readdatavalid),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_write(master_write),
    .master_writedata(master_writedata), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid), .busy(busy), .grant_id(grant_id)
  );

  typedef struct { int id; bit rd; logic [31:0] addr; logic [31:0] wd; } txn_t;
  typedef struct { int id; logic [31:0] data; } rdv_t;

  txn_t exp_q[$];
  rdv_t rdv_q[$];
  int   acc_ids[$];
  int   checks = 0;
  int   errors = 0;

  // Requester models: 0 idle, 1 command held, 2 waiting for read data
  int          rq_st   [N];
  bit          rq_r    [N];
  bit          rq_w    [N];
  bit          rq_pawn [N];
  bit          d_r     [N];
  bit          d_w     [N];
  logic [31:0] rq_addr [N];
  logic [31:0] rq_wd   [N];

  // Reference model: 0 free, 1 command on the bus, 2 awaiting read data
  int m_phase, m_last, m_gid, m_lat;
  bit m_rd;
  int cur_phase, cur_gid;
  int wait_pct, lat_max, stray_pct;
  bit allow_new, mon_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input int i, input bit r, input bit w, input bit pawn);
    rq_st[i]   = 1;
    rq_r[i]    = r;
    rq_w[i]    = w;
    rq_pawn[i] = pawn;
    rq_addr[i] = $urandom;
    rq_wd[i]   = $urandom;
  endtask

  task automatic step(input bit do_rst);
    logic [N-1:0] o_wr, o_rdv;
    bit rdv;
    int w, idx, kind;
    @(negedge clk); #4;
    o_wr  = req_waitrequest;
    o_rdv = req_readdatavalid;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (do_rst) rq_st[i] = 0;
      else if (rq_st[i] == 1 && !o_wr[IDW'(i)]) rq_st[i] = rq_r[i] ? 2 : 0;
      else if (rq_st[i] == 2 && o_rdv[IDW'(i)]) rq_st[i] = 0;
      if (rq_st[i] == 0 && allow_new && !do_rst && $urandom_range(0, 3) == 0) begin
        kind = $urandom_range(0, 3);
        issue(i, kind != 2, kind >= 2, 1'($urandom_range(0, 1)));
      end
      d_r[i] = (rq_st[i] == 1 || (rq_st[i] == 2 && rq_pawn[i])) && rq_r[i];
      d_w[i] = (rq_st[i] == 1 || (rq_st[i] == 2 && rq_pawn[i])) && rq_w[i];
      req_read[IDW'(i)]        = d_r[i];
      req_write[IDW'(i)]       = d_w[i];
      req_address_a[IDW'(i)]   = rq_addr[i];
      req_writedata_a[IDW'(i)] = rq_wd[i];
    end
    cur_phase = m_phase;
    cur_gid   = m_gid;
    master_waitrequest = ($urandom_range(0, 99) < wait_pct);
    master_readdata    = $urandom;
    rdv = 1'b0;
    if (!do_rst) begin
      if (cur_phase == 2) begin
        if (m_lat == 0) rdv = 1'b1;
        else m_lat = m_lat - 1;
      end else if ($urandom_range(0, 99) < stray_pct) rdv = 1'b1;
    end
    master_readdatavalid = rdv;
    rst_n = !do_rst;
    if (do_rst) begin
      m_phase = 0; m_last = N - 1; m_gid = 0; m_lat = 0;
    end else begin
      case (cur_phase)
        0: begin
          w = -1;
          for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (w < 0 && (d_r[idx] || d_w[idx])) w = idx;
          end
          if (w >= 0) begin
            exp_q.push_back('{w, d_r[w], rq_addr[w], rq_wd[w]});
            m_rd = d_r[w]; m_gid = w; m_last = w; m_phase = 1;
          end
        end
        1: if (!master_waitrequest) begin
          m_phase = m_rd ? 2 : 0;
          m_lat   = $urandom_range(0, lat_max);
        end
        default: if (rdv) begin
          rdv_q.push_back('{m_gid, master_readdata});
          m_phase = 0;
        end
      endcase
    end
  endtask

  initial begin
    logic [N-1:0] e_wr, oh;
    txn_t t;
    rdv_t r;
    forever begin
      @(negedge clk); #4;
      if (mon_en) begin
        e_wr = '1;
        if (cur_phase == 1 && !master_waitrequest) e_wr[IDW'(cur_gid)] = 1'b0;
        chk("busy", 32'(busy), 32'(cur_phase != 0));
        chk("grant_id", 32'(grant_id), cur_gid);
        chk("req_waitrequest", 32'(req_waitrequest), 32'(e_wr));
        chk("readdata_bcast", req_readdata, master_readdata);
        if (cur_phase != 1)
          chk("master_idle", master_address | master_writedata | 32'({master_read, master_write}), 0);
        if ((master_read || master_write) && !master_waitrequest) begin
          acc_ids.push_back(int'(grant_id));
          if (exp_q.size() == 0) chk("accept_expected", exp_q.size(), 1);
          else begin
            t = exp_q.pop_front();
            chk("acc_id", 32'(grant_id), t.id);
            chk("acc_read", 32'(master_read), 32'(t.rd));
            chk("acc_write", 32'(master_write), 32'(!t.rd));
            chk("acc_addr", master_address, t.addr);
            chk("acc_wdata", master_writedata, t.wd);
          end
        end
        if (req_readdatavalid != '0) begin
          if (rdv_q.size() == 0) chk("rdv_unexpected", 32'(req_readdatavalid), 0);
          else begin
            r = rdv_q.pop_front();
            oh = '0;
            oh[IDW'(r.id)] = 1'b1;
            chk("rdv_onehot", 32'(req_readdatavalid), 32'(oh));
            chk("rdv_data", req_readdata, r.data);
          end
        end
        chk("rdv_missing", rdv_q.size(), 0);
        rdv_q.delete();
      end
    end
  end

  initial begin
    int n, nbusy;
    rst_n = 1'b0;
    req_read = '0; req_write = '0; req_address_a = '0; req_writedata_a = '0;
    master_waitrequest = 1'b1; master_readdata = '0; master_readdatavalid = 1'b0;
    for (int i = 0; i < N; i++) begin
      rq_st[i] = 0; rq_r[i] = 0; rq_w[i] = 0; rq_pawn[i] = 0; rq_addr[i] = 0; rq_wd[i] = 0;
    end
    m_phase = 0; m_last = N - 1; m_gid = 0; m_lat = 0; m_rd = 0;
    cur_phase = 0; cur_gid = 0;
    wait_pct = 0; lat_max = 0; stray_pct = 0; allow_new = 0; mon_en = 0;
    step(1);
    mon_en = 1;
    step(1);

    // Every requester holds a read with a zero-latency slave.
    for (int i = 0; i < N; i++) issue(i, 1, 0, 1);
    acc_ids.delete();
    repeat (20) step(0);
    chk("fair_count", acc_ids.size(), N);
    for (int i = 0; i < N && i < acc_ids.size(); i++) chk("fair_order", acc_ids[i], i);

    wait_pct = 40; lat_max = 3; stray_pct = 10; allow_new = 1;
    repeat (1500) step(0);

    n = 0;
    while (n < 300 && !(cur_phase == 2 && m_phase == 2)) begin
      step(0);
      n++;
    end
    chk("reach_rd_wait", 32'(cur_phase == 2 && m_phase == 2), 1);
    allow_new = 0;
    step(1);
    stray_pct = 100;
    repeat (4) step(0);
    stray_pct = 0;
    issue(1, 1, 0, 0);
    issue(0, 0, 1, 0);
    issue(3, 1, 1, 0);
    acc_ids.delete();
    repeat (40) step(0);
    chk("restart_count", acc_ids.size(), 3);
    if (acc_ids.size() >= 3) begin
      chk("restart_first", acc_ids[0], 0);
      chk("restart_second", acc_ids[1], 1);
      chk("restart_third", acc_ids[2], 3);
    end

    allow_new = 1; stray_pct = 10;
    repeat (400) step(0);
    allow_new = 0;
    repeat (200) step(0);
    nbusy = 0;
    for (int i = 0; i < N; i++) if (rq_st[i] != 0) nbusy++;
    chk("drain_requesters", nbusy, 0);
    chk("drain_exp_q", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_master_arbiter.md
# move_master_arbiter

Round-robin arbiter that shares the single SDRAM-facing Avalon-MM master port among N move-generation accelerators (pawn, knight, sliding-piece, etc.), each of which owns its own Avalon master. It sits between the accelerators' master ports and the Qsys interconnect. It serialises their board-square reads and move-list writes with at most one transaction outstanding, and routes read data back to the issuing requester.

## Interface
- N_REQ, 4: number of requesters; legal range 2..8.
- IDW, $clog2(N_REQ): width of grant index.

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_address  in  N_REQ*32  requester i address in bits [32i+31:32i]
- req_read  in  N_REQ  read request per requester
- req_write  in  N_REQ  write request per requester
- req_writedata  in  N_REQ*32  write data per requester, same packing as req_address
- req_waitrequest  out  N_REQ  per-requester waitrequest
- req_readdata  out  32  broadcast copy of master_readdata
- req_readdatavalid  out  N_REQ  one-hot read-data strobe to the owning requester
- master_waitrequest  in  1  from interconnect
- master_address  out  32  to interconnect
- master_read  out  1  to interconnect
- master_write  out  1  to interconnect
- master_writedata  out  32  to interconnect
- master_readdata  in  32  from interconnect
- master_readdatavalid  in  1  from interconnect
- busy  out  1  high in any state other than IDLE
- grant_id  out  IDW  index of current/last granted requester

## Operation
- Requester i is "requesting" when req_read[i] | req_write[i]. If both are high, the request is treated as a read.
- States:
  - IDLE: if any requester is requesting, latch winner into grant_id and go to GRANT; else stay.
  - GRANT: drive the winner's command onto the master port.
    - When master_waitrequest=0: a read goes to RD_WAIT; a write goes to IDLE.
    - Otherwise stay in GRANT.
  - RD_WAIT: master_read=0, master_write=0. On master_readdatavalid=1, pulse req_readdatavalid[grant_id] for that cycle and go to IDLE.
- Round-robin: a last-grant pointer resets to N_REQ-1, so requester 0 wins first. The search starts at last+1 mod N_REQ and wraps; the first requester found wins. The pointer updates to the winner on the IDLE->GRANT transition.
- Command forwarding is combinational from the grant_id mux and is active only in GRANT. Outside GRANT, master_read=0, master_write=0, master_address=0 and master_writedata=0.
- req_waitrequest[i]=0 only when state=GRANT, i==grant_id and master_waitrequest=0; otherwise 1.
  - Requesters that hold read high until readdatavalid (e.g. pawn) must not be re-issued. Re-arbitration happens only from IDLE, which is entered only after data returns.
- req_readdatavalid is all-zero except in RD_WAIT. master_readdatavalid arriving in IDLE or GRANT is a stray response: it is dropped and not forwarded.
- Requests withdrawn before grant are simply not seen. A requester must hold its command in GRANT until waitrequest drops; the arbiter does not check this.
- req_readdata = master_readdata at all times.

## Timing
- Reset values:
  - state=IDLE, last pointer=N_REQ-1, grant_id=0, busy=0
  - req_waitrequest all ones, req_readdatavalid all zeros
  - master_read, master_write, master_address and master_writedata all 0
- Reset mid-transaction: abandon at the next clk edge. A response arriving later is dropped per the stray rule.
- Arbitration latency: request present in IDLE at edge t means master command asserted in cycle t+1 (GRANT).
- Read: readdatavalid cannot coincide with acceptance. Minimum read occupancy is 3 cycles (IDLE, GRANT, RD_WAIT). The next grant can start 1 cycle after the readdatavalid cycle.
- Write: minimum occupancy is 2 cycles (IDLE, GRANT with waitrequest=0).
- Back-to-back requesters: one IDLE cycle occurs between consecutive transactions. There is no bypass.
- There is no timeout. A missing readdatavalid hangs in RD_WAIT until reset.

## Test plan
- Single read: after reset, req_read[2]=1, address 0x1000, 2 wait cycles, data 0xFFFFFFFF 3 cycles later -> master_address=0x1000; req_waitrequest[2] low for 1 cycle; req_readdatavalid=4'b0100 with readdata 0xFFFFFFFF; then IDLE.
- Fairness: all four hold req_read with zero-latency slave -> grant order 0,1,2,3,0. No requester gets two grants while another waits.
- Write path: req_write[1]=1, data 0x00000005, address 0x2004, waitrequest high 3 cycles -> master_write held 4 cycles; req_waitrequest[1]=0 only in the last of those cycles; back to IDLE next cycle; no readdatavalid pulse.
- Pawn-style hold: requester 0 keeps read=1 through RD_WAIT -> exactly one master_read acceptance; requester 0 not re-granted until after its readdatavalid.
- Read+write simultaneous on requester 3 -> master_read=1, master_write=0.
- Reset mid-read: assert rst_n=0 in RD_WAIT, release, then inject stray readdatavalid in IDLE -> no req_readdatavalid pulse; grant order restarts at requester 0.
